// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and rise-to-rise period of an asynchronous
// PWM input in clk cycles. It publishes one measurement per complete period
// with a single-cycle strobe, and raises a stale flag when no rising edge
// arrives within TIMEOUT cycles.
// Optional build macro: GLITCH_FILTER_EN adds a FILTER_LEN-cycle glitch filter
// after the synchroniser.
module pwm_capture #(
  parameter int                CNT_W      = 27,
  parameter logic [CNT_W-1:0]  TIMEOUT    = 27'd100_000_000,
  parameter int                FILTER_LEN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic             level,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             meas_valid,
  output logic             stale
);

  // FILTER_LEN must fit the 4-bit run counter and be long enough to mean something.
  if (FILTER_LEN < 2 || FILTER_LEN > 15) begin : g_bad_filter_len
    $error("pwm_capture: FILTER_LEN must be in 2..15");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             prev_q, prev_d;
  logic             c;
  logic             rise, fall;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] high_lat_q, high_lat_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic             meas_valid_q, meas_valid_d;
  logic             stale_q, stale_d;

  // Synchroniser and edge-history next-state.
  always_comb begin
    s1_d   = pwm_in;
    s2_d   = s1_q;
    prev_d = c;
  end

  // Synchroniser and history registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
    end
  end

`ifdef GLITCH_FILTER_EN
  localparam logic [3:0] FILT_LAST = 4'(FILTER_LEN - 1);

  logic       filt_q, filt_d;
  logic [3:0] run_q, run_d;

  // Filter: follow s2 only after it has disagreed for FILTER_LEN cycles in a row.
  always_comb begin
    filt_d = filt_q;
    run_d  = 4'd0;
    if (s2_q != filt_q) begin
      if (run_q == FILT_LAST) begin
        filt_d = s2_q;
      end else begin
        run_d = run_q + 4'd1;
      end
    end
  end

  // Filter state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      filt_q <= 1'b0;
      run_q  <= 4'd0;
    end else begin
      filt_q <= filt_d;
      run_q  <= run_d;
    end
  end

  assign c = filt_q;
`else
  assign c = s2_q;
`endif

  assign rise = c & ~prev_q;
  assign fall = ~c & prev_q;

  // Cycle counter: restarts at 1 on each rise, saturates at TIMEOUT.
  always_comb begin
    cnt_d = cnt_q;
    if (rise) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q != TIMEOUT) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Measurement FSM. A rise takes priority over the timeout; the timeout takes
  // priority over a fall, so a saturated high time never reaches high_lat.
  always_comb begin
    state_d      = state_q;
    high_lat_d   = high_lat_q;
    high_cnt_d   = high_cnt_q;
    period_cnt_d = period_cnt_q;
    meas_valid_d = 1'b0;
    stale_d      = stale_q;
    if (rise) begin
      if (state_q == IDLE) begin
        // First rise only arms the measurement; nothing before it is trusted.
        state_d = HIGH;
      end else begin
        // HIGH cannot legally see a rise without a fall; handled as LOW.
        high_cnt_d   = high_lat_q;
        period_cnt_d = cnt_q;
        meas_valid_d = 1'b1;
        stale_d      = 1'b0;
        state_d      = HIGH;
      end
    end else if (cnt_q == TIMEOUT) begin
      stale_d = 1'b1;
      state_d = IDLE;
    end else if (fall && state_q == HIGH) begin
      high_lat_d = cnt_q;
      state_d    = LOW;
    end
  end

  // Counter, FSM and registered output flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      high_lat_q   <= '0;
      high_cnt_q   <= '0;
      period_cnt_q <= '0;
      meas_valid_q <= 1'b0;
      stale_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      high_lat_q   <= high_lat_d;
      high_cnt_q   <= high_cnt_d;
      period_cnt_q <= period_cnt_d;
      meas_valid_q <= meas_valid_d;
      stale_q      <= stale_d;
    end
  end

  assign level      = c;
  assign high_cnt   = high_cnt_q;
  assign period_cnt = period_cnt_q;
  assign meas_valid = meas_valid_q;
  assign stale      = stale_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Testbench for pwm_capture with TIMEOUT=1000. The driver pushes the expected
// (high, period) pair of each complete period into a queue when the rise that
// closes it is driven; the monitor pops and compares on every meas_valid.
module tb_pwm_capture;

  localparam int          CNT_W = 27;
  localparam logic [26:0] TO    = 27'd1000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             pwm_in = 1'b0;
  logic             level;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] period_cnt;
  logic             meas_valid;
  logic             stale;

  pwm_capture #(
    .CNT_W      (CNT_W),
    .TIMEOUT    (TO),
    .FILTER_LEN (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pwm_in     (pwm_in),
    .level      (level),
    .high_cnt   (high_cnt),
    .period_cnt (period_cnt),
    .meas_valid (meas_valid),
    .stale      (stale)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int h;
    int p;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  // Driver-side model state
  bit have_prev = 1'b0;
  int ph = 0;
  int pl = 0;

  // Interval checking between consecutive strobes
  bit chk_int = 1'b0;
  int exp_int = 0;
  bit last_flag = 1'b0;
  int last_meas_cyc = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One PWM period; the rise that opens it closes the previous one.
  task automatic drive_period(input int h, input int l);
    if (have_prev) exp_q.push_back('{ph, ph + pl});
    have_prev = 1'b1;
    ph = h;
    pl = l;
    pwm_in = 1'b1;
    tick(h);
    pwm_in = 1'b0;
    tick(l);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_level"}, int'(level), 0);
    check({tag, "_high"}, int'(high_cnt), 0);
    check({tag, "_period"}, int'(period_cnt), 0);
    check({tag, "_valid"}, int'(meas_valid), 0);
    check({tag, "_stale"}, int'(stale), 0);
  endtask

  // Monitor: one line per published measurement.
  always @(negedge clk) begin
    if (rst_n && meas_valid) begin
      $display("meas cycle=%0d high=%0d period=%0d stale=%0d",
               cyc, high_cnt, period_cnt, stale);
      if (exp_q.size() == 0) begin
        check("unexpected_meas", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("high_cnt", int'(high_cnt), mon_e.h);
        check("period_cnt", int'(period_cnt), mon_e.p);
      end
      check("stale_at_meas", int'(stale), 0);
      if (chk_int && last_flag) check("meas_interval", cyc - last_meas_cyc, exp_int);
      last_flag     = chk_int;
      last_meas_cyc = cyc;
    end
  end

  initial begin
    int got;

    // Reset state
    rst_n = 1'b0;
    tick(3);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Stale after reset with no edges: sets at TIMEOUT
    tick(990);
    check("stale_before_timeout", int'(stale), 0);
    tick(20);
    check("stale_after_timeout", int'(stale), 1);

    // Steady 30/70, one strobe per 100 cycles
    exp_int = 100;
    chk_int = 1'b1;
    repeat (6) drive_period(30, 70);
    chk_int = 1'b0;
    check("steady_stale", int'(stale), 0);

    // Hold high: stale TIMEOUT cycles after the last rise, counts hold
    if (have_prev) exp_q.push_back('{ph, ph + pl});
    have_prev = 1'b0;
    pwm_in = 1'b1;
    got = 0;
    for (int i = 0; i < 1300; i++) begin
      tick(1);
      if (stale) begin
        got = 1;
        break;
      end
    end
    check("stale_set", got, 1);
    check("stale_delay", cyc - last_meas_cyc, 1000);
    check("hold_level", int'(level), 1);
    check("hold_high", int'(high_cnt), 30);
    check("hold_period", int'(period_cnt), 100);
    tick(50);
    check("stale_held", int'(stale), 1);
    pwm_in = 1'b0;
    tick(10);
    check("low_level", int'(level), 0);
    check("stale_until_meas", int'(stale), 1);
    repeat (3) drive_period(30, 70);
    check("resume_stale", int'(stale), 0);

`ifndef GLITCH_FILTER_EN
    // Fastest input: 1/1
    drive_period(1, 1);
    exp_int = 2;
    chk_int = 1'b1;
    repeat (7) drive_period(1, 1);
    chk_int = 1'b0;
`endif

    // 2-cycle glitch in the middle of LOW
`ifdef GLITCH_FILTER_EN
    if (have_prev) exp_q.push_back('{ph, ph + pl});
    have_prev = 1'b1;
    ph = 30;
    pl = 70;
    pwm_in = 1'b1; tick(30);
    pwm_in = 1'b0; tick(30);
    pwm_in = 1'b1; tick(2);
    pwm_in = 1'b0; tick(38);
`else
    drive_period(30, 30);
    drive_period(2, 38);
`endif
    repeat (2) drive_period(30, 70);

    // Duty switch at a period boundary
    repeat (3) drive_period(20, 80);
    repeat (3) drive_period(50, 50);

    // Reset mid-HIGH
    if (have_prev) exp_q.push_back('{ph, ph + pl});
    have_prev = 1'b0;
    pwm_in = 1'b1;
    tick(10);
    rst_n = 1'b0;
    pwm_in = 1'b0;
    tick(1);
    check_all_zero("midreset");
    rst_n = 1'b1;
    tick(20);
    repeat (3) drive_period(40, 60);
    tick(30);
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
